// File: rtl/rot_delay_pipe.sv
// rot_delay_pipe: elastic DEPTH-stage delay line applying a per-beat transform on every hop
module rot_delay_pipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int ROT   = 1,
  localparam int OW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_mode,
  output logic [OW-1:0]    occupancy
);

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [1:0]       r_mode [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [OW-1:0]    r_occ;
  logic             w_advance;
  logic             w_accept;
  logic             w_take;

  // Transform applied to a beat as it moves one stage forward, chosen by its own stored mode
  function automatic logic [WIDTH-1:0] hop(input logic [WIDTH-1:0] d, input logic [1:0] m);
    return m == 2'd1 ? {d[WIDTH-1-ROT:0], d[WIDTH-1:WIDTH-ROT]} :
           m == 2'd2 ? {d[ROT-1:0], d[WIDTH-1:ROT]} :
           m == 2'd3 ? ~d : d;
  endfunction

  assign w_advance = !r_valid[DEPTH-1] | out_ready;
  assign in_ready  = w_advance & !flush & !rst;
  assign w_accept  = in_valid & in_ready;
  assign w_take    = r_valid[DEPTH-1] & out_ready & !flush;
  assign out_valid = r_valid[DEPTH-1];
  assign out_data  = r_data[DEPTH-1];
  assign out_mode  = r_mode[DEPTH-1];
  assign occupancy = r_occ;

  // Rigid shift of the whole chain; flush only drops valid bits and leaves data stale
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_data[k] <= '0;
        r_mode[k] <= '0;
      end
    end else if (flush) begin
      r_valid <= '0;
    end else if (w_advance) begin
      r_valid <= {r_valid[DEPTH-2:0], w_accept};
      if (w_accept) begin
        r_data[0] <= in_data;
        r_mode[0] <= in_mode;
      end
      for (int k = 1; k < DEPTH; k++) begin
        r_data[k] <= hop(r_data[k-1], r_mode[k-1]);
        r_mode[k] <= r_mode[k-1];
      end
    end
  end

  // Occupancy tracks accepts minus completed output handshakes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_occ <= '0;
    else if (flush) r_occ <= '0;
    else r_occ <= r_occ + OW'(w_accept) - OW'(w_take);
  end

endmodule
